commit_ctrl: RTL and testbench

Retire-stage controller between the reorder buffer and the architectural state. Each cycle it qualifies the up-to-3 oldest ROB entries, issues architectural-RAT writes and physical-register releases for those that retire, and on an excepting oldest entry runs the flush/recovery sequence: pulse `flush`, freeze the front end, restore the speculative RAT and free list. It also keeps retire and exception counters for debug.

---
 rtl/core_pkg.sv | 30 +++
 rtl/commit_ctrl_if.sv | 40 ++++
 rtl/commit_ctrl_select.sv | 36 +++
 rtl/commit_ctrl.sv | 141 ++++++++++++++
 tb/tb_commit_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg
// Shared retire-stage definitions: retire width, register-index widths,
// the "no destination" instruction type, the commit FSM state type and a
// small population-count helper for the retire counter.
package core_pkg;

  localparam int NUM_RET = 3;
  localparam int PREG_W  = 5;
  localparam int AREG_W  = 3;
  localparam int RET_CNT_W = $clog2(NUM_RET + 1);

  localparam logic [1:0] TYPE_NODEST = 2'b11;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    RECOVER
  } commit_state_t;

  // Number of slots set in a retire vector.
  function automatic logic [RET_CNT_W-1:0] count_ones(input logic [NUM_RET-1:0] v);
    logic [RET_CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      n = n + RET_CNT_W'(v[k]);
    end
    return n;
  endfunction

endpackage

// File: rtl/commit_ctrl_if.sv
// commit_ctrl_if
// Bundle between the ROB head / architectural state and the retire
// controller.
//   ROB head (master -> slave): ready_ret, excep_ret, Type_ret, Pw_ret,
//     Pw_old_ret, Rw_ret, one entry per retire slot.
//   Retire results (slave -> master): commit_en, arat_we/arat_Rw/arat_Pw,
//     free_valid/free_Pw, flush, freeze_front, restore_rat.
interface commit_ctrl_if;
  import core_pkg::*;

  logic [NUM_RET-1:0]             ready_ret;
  logic [NUM_RET-1:0]             excep_ret;
  logic [NUM_RET-1:0][1:0]        Type_ret;
  logic [NUM_RET-1:0][PREG_W-1:0] Pw_ret;
  logic [NUM_RET-1:0][PREG_W-1:0] Pw_old_ret;
  logic [NUM_RET-1:0][AREG_W-1:0] Rw_ret;

  logic [NUM_RET-1:0]             commit_en;
  logic [NUM_RET-1:0]             arat_we;
  logic [NUM_RET-1:0][AREG_W-1:0] arat_Rw;
  logic [NUM_RET-1:0][PREG_W-1:0] arat_Pw;
  logic [NUM_RET-1:0]             free_valid;
  logic [NUM_RET-1:0][PREG_W-1:0] free_Pw;
  logic                           flush;
  logic                           freeze_front;
  logic                           restore_rat;

  modport master (
    output ready_ret, excep_ret, Type_ret, Pw_ret, Pw_old_ret, Rw_ret,
    input  commit_en, arat_we, arat_Rw, arat_Pw, free_valid, free_Pw,
           flush, freeze_front, restore_rat
  );

  modport slave (
    input  ready_ret, excep_ret, Type_ret, Pw_ret, Pw_old_ret, Rw_ret,
    output commit_en, arat_we, arat_Rw, arat_Pw, free_valid, free_Pw,
           flush, freeze_front, restore_rat
  );

endinterface

// File: rtl/commit_ctrl_select.sv
// commit_select
// Purely combinational retire qualification.
//   state      : current commit FSM state (only RUN may retire)
//   ready_ret  : per-slot ready, already prefix-qualified by the ROB
//   excep_ret  : per-slot exception flag
//   commit_en  : slots retiring this cycle (contiguous from slot 0)
//   excep_hit  : the first non-retiring slot is ready and excepting
//   excep_slot : one-hot position of that excepting slot
module commit_select
  import core_pkg::*;
(
  input  commit_state_t      state,
  input  logic [NUM_RET-1:0] ready_ret,
  input  logic [NUM_RET-1:0] excep_ret,
  output logic [NUM_RET-1:0] commit_en,
  output logic               excep_hit,
  output logic [NUM_RET-1:0] excep_slot
);

  // "older" carries whether every older slot retired; the first slot that
  // fails to retire kills it, so at most one excep_slot bit can be set.
  always_comb begin
    logic older;
    older      = (state == RUN);
    commit_en  = '0;
    excep_slot = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      commit_en[k]  = older & ready_ret[k] & ~excep_ret[k];
      excep_slot[k] = older & ready_ret[k] &  excep_ret[k];
      older         = commit_en[k];
    end
  end

  assign excep_hit = |excep_slot;

endmodule

// File: rtl/commit_ctrl.sv
// commit_ctrl
// Retire-stage controller: retires up to NUM_RET ROB head entries per
// cycle, writes the architectural RAT, releases old physical registers,
// and sequences flush/recovery when the oldest non-retiring entry excepts.
//   clk, rst     : core clock, asynchronous active-low reset
//   rob          : ROB head inputs and retire/flush outputs (slave side)
//   excep_Rw     : destination of the last excepting instruction (sticky)
//   cnt_retired  : saturating count of retired instructions
//   cnt_excep    : saturating count of exceptions taken
module commit_ctrl
  import core_pkg::*;
#(
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  commit_ctrl_if.slave      rob,
  output logic [AREG_W-1:0] excep_Rw,
  output logic [CNT_W-1:0]  cnt_retired,
  output logic [CNT_W-1:0]  cnt_excep
);

  localparam logic [3:0] REC_LOAD = 4'(RECOVER_CYCLES - 1);

  commit_state_t      state;
  logic [3:0]         rec_cnt;
  logic               flush_q;
  logic               freeze_q;
  logic               restore_q;

  logic [NUM_RET-1:0] sel_en;
  logic               excep_hit;
  logic [NUM_RET-1:0] excep_slot;
  logic [NUM_RET-1:0] commit_live;
  logic               run_live;
  logic [AREG_W-1:0]  excep_rw_sel;
  logic [CNT_W:0]     ret_sum;

  commit_select u_select (
    .state      (state),
    .ready_ret  (rob.ready_ret),
    .excep_ret  (rob.excep_ret),
    .commit_en  (sel_en),
    .excep_hit  (excep_hit),
    .excep_slot (excep_slot)
  );

  // Commit outputs are combinational, so reset has to force them low
  // directly; the state register alone would leave them following the ROB.
  assign run_live    = (state == RUN) & rst;
  assign commit_live = sel_en & {NUM_RET{rst}};

  always_comb begin
    rob.commit_en  = commit_live;
    rob.arat_we    = '0;
    rob.free_valid = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      rob.arat_we[k]    = commit_live[k] & (rob.Type_ret[k] != TYPE_NODEST);
      rob.free_valid[k] = commit_live[k] & (rob.Type_ret[k] != TYPE_NODEST);
    end
    rob.arat_Rw = run_live ? rob.Rw_ret     : '0;
    rob.arat_Pw = run_live ? rob.Pw_ret     : '0;
    rob.free_Pw = run_live ? rob.Pw_old_ret : '0;
  end

  assign rob.flush        = flush_q;
  assign rob.freeze_front = freeze_q;
  assign rob.restore_rat  = restore_q;

  // excep_slot is one-hot, so OR-ing the gated Rw fields selects it.
  always_comb begin
    excep_rw_sel = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (excep_slot[k]) begin
        excep_rw_sel = excep_rw_sel | rob.Rw_ret[k];
      end
    end
  end

  // Flush/freeze/restore are registered alongside the state so they change
  // on the same edge as the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      rec_cnt   <= '0;
      flush_q   <= 1'b0;
      freeze_q  <= 1'b0;
      restore_q <= 1'b0;
      excep_Rw  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (excep_hit) begin
            state     <= FLUSH;
            flush_q   <= 1'b1;
            freeze_q  <= 1'b1;
            restore_q <= 1'b1;
            excep_Rw  <= excep_rw_sel;
          end
        end
        FLUSH: begin
          state     <= RECOVER;
          rec_cnt   <= REC_LOAD;
          flush_q   <= 1'b0;
          restore_q <= 1'b0;
        end
        RECOVER: begin
          if (rec_cnt == 4'd0) begin
            state    <= RUN;
            freeze_q <= 1'b0;
          end else begin
            rec_cnt <= rec_cnt - 4'd1;
          end
        end
        default: begin
          state     <= RUN;
          flush_q   <= 1'b0;
          freeze_q  <= 1'b0;
          restore_q <= 1'b0;
        end
      endcase
    end
  end

  // One extra bit on the sum exposes overflow, which pins the counter.
  assign ret_sum = {1'b0, cnt_retired} + (CNT_W+1)'(count_ones(sel_en));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_retired <= '0;
      cnt_excep   <= '0;
    end else begin
      cnt_retired <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
      if (excep_hit && (cnt_excep != '1)) begin
        cnt_excep <= cnt_excep + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl
// Directed bench for commit_ctrl with a cycle-level reference model.
// The model tracks how many cycles the front end stays frozen after an
// exception, plus the counters and sticky excepting Rw; a compare process
// checks every DUT output against it at each falling clock edge, while the
// directed sequence pins key values with hand-computed literals.
module tb_commit_ctrl;
  import core_pkg::*;

  localparam int RC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    excep_Rw;
  logic [CW-1:0] cnt_retired;
  logic [CW-1:0] cnt_excep;

  int checks = 0;
  int errors = 0;

  commit_ctrl_if bus ();

  commit_ctrl #(.RECOVER_CYCLES(RC), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rob         (bus),
    .excep_Rw    (excep_Rw),
    .cnt_retired (cnt_retired),
    .cnt_excep   (cnt_excep)
  );

  always #5 clk = ~clk;

  // Compares one value and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one set of ROB head values just after a rising edge.
  task automatic applyStimulus(input logic [2:0] rdy, input logic [2:0] exc,
                               input logic [5:0] typ, input logic [14:0] pw,
                               input logic [14:0] pwo, input logic [8:0] rw);
    @(posedge clk);
    #1;
    bus.ready_ret  = rdy;
    bus.excep_ret  = exc;
    bus.Type_ret   = typ;
    bus.Pw_ret     = pw;
    bus.Pw_old_ret = pwo;
    bus.Rw_ret     = rw;
  endtask

  task automatic idleCycle();
    applyStimulus(3'b000, 3'b000, 6'd0, 15'd0, 15'd0, 9'd0);
  endtask

  // Reference model state: frozen cycles remaining (flush cycle included).
  int         m_frozen = 0, n_frozen = 0;
  int         m_ret = 0,    n_ret = 0;
  int         m_exc = 0,    n_exc = 0;
  logic [2:0] m_rw = '0,    n_rw = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_frozen = 0; m_ret = 0; m_exc = 0; m_rw = '0;
    end else begin
      m_frozen = n_frozen; m_ret = n_ret; m_exc = n_exc; m_rw = n_rw;
    end
  end

  logic [2:0]  e_commit, e_we;
  logic [8:0]  e_arw;
  logic [14:0] e_apw, e_fpw;
  logic        e_flush, e_freeze, running, trig;
  logic [2:0]  trig_rw;
  int          e_ret, e_exc;
  logic [2:0]  e_rw;

  always @(negedge clk) begin
    running  = (m_frozen == 0);
    e_commit = '0;
    trig     = 1'b0;
    trig_rw  = '0;
    if (running) begin
      for (int k = 0; k < 3; k++) begin
        if (bus.ready_ret[k] && !bus.excep_ret[k]) begin
          e_commit[k] = 1'b1;
        end else begin
          if (bus.ready_ret[k] && bus.excep_ret[k]) begin
            trig    = 1'b1;
            trig_rw = bus.Rw_ret[k];
          end
          break;
        end
      end
    end
    for (int k = 0; k < 3; k++) e_we[k] = e_commit[k] && (bus.Type_ret[k] != 2'b11);
    e_arw    = running ? bus.Rw_ret     : 9'd0;
    e_apw    = running ? bus.Pw_ret     : 15'd0;
    e_fpw    = running ? bus.Pw_old_ret : 15'd0;
    e_flush  = (m_frozen == RC + 1);
    e_freeze = (m_frozen > 0);
    e_ret    = m_ret;
    e_exc    = m_exc;
    e_rw     = m_rw;
    if (!rst) begin
      e_commit = '0; e_we = '0; e_arw = '0; e_apw = '0; e_fpw = '0;
      e_flush = 1'b0; e_freeze = 1'b0;
    end
    checkOutput("commit_en",    32'(bus.commit_en),    32'(e_commit));
    checkOutput("arat_we",      32'(bus.arat_we),      32'(e_we));
    checkOutput("free_valid",   32'(bus.free_valid),   32'(e_we));
    checkOutput("arat_Rw",      32'(bus.arat_Rw),      32'(e_arw));
    checkOutput("arat_Pw",      32'(bus.arat_Pw),      32'(e_apw));
    checkOutput("free_Pw",      32'(bus.free_Pw),      32'(e_fpw));
    checkOutput("flush",        32'(bus.flush),        32'(e_flush));
    checkOutput("restore_rat",  32'(bus.restore_rat),  32'(e_flush));
    checkOutput("freeze_front", 32'(bus.freeze_front), 32'(e_freeze));
    checkOutput("cnt_retired",  32'(cnt_retired),      32'(e_ret));
    checkOutput("cnt_excep",    32'(cnt_excep),        32'(e_exc));
    checkOutput("excep_Rw",     32'(excep_Rw),         32'(e_rw));
    // Next-cycle model values.
    n_frozen = trig ? RC + 1 : (m_frozen > 0 ? m_frozen - 1 : 0);
    n_ret    = m_ret + $countones(e_commit);
    if (n_ret > CMAX) n_ret = CMAX;
    n_exc    = (trig && m_exc < CMAX) ? m_exc + 1 : m_exc;
    n_rw     = trig ? trig_rw : m_rw;
  end

  initial begin
    bus.ready_ret = '0; bus.excep_ret = '0; bus.Type_ret = '0;
    bus.Pw_ret = '0; bus.Pw_old_ret = '0; bus.Rw_ret = '0;
    #3;
    checkOutput("reset_commit_en", 32'(bus.commit_en), 32'd0);
    checkOutput("reset_freeze",    32'(bus.freeze_front), 32'd0);
    checkOutput("reset_cnt_ret",   32'(cnt_retired), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;

    // All three retire, Types {0,1,2}, Pw_old {7,8,9}.
    applyStimulus(3'b111, 3'b000, {2'd2, 2'd1, 2'd0}, {5'd22, 5'd21, 5'd20},
                  {5'd9, 5'd8, 5'd7}, {3'd3, 3'd2, 3'd1});
    #2;
    checkOutput("all_commit_en",  32'(bus.commit_en),  32'b111);
    checkOutput("all_free_valid", 32'(bus.free_valid), 32'b111);
    checkOutput("all_free_Pw",    32'(bus.free_Pw),    32'({5'd9, 5'd8, 5'd7}));

    // Slot1 has no destination.
    applyStimulus(3'b011, 3'b000, {2'd0, 2'b11, 2'd1}, {5'd12, 5'd11, 5'd10},
                  {5'd3, 5'd2, 5'd1}, {3'd5, 3'd4, 3'd3});
    #2;
    checkOutput("nodest_commit_en", 32'(bus.commit_en),  32'b011);
    checkOutput("nodest_arat_we",   32'(bus.arat_we),    32'b001);
    checkOutput("nodest_free_vld",  32'(bus.free_valid), 32'b001);
    checkOutput("first_cnt_ret",    32'(cnt_retired),    32'd3);

    // Slot0 retires, slot1 excepts with Rw=4; inputs held during recovery.
    applyStimulus(3'b011, 3'b010, {2'd0, 2'd0, 2'd0}, {5'd15, 5'd14, 5'd13},
                  {5'd6, 5'd5, 5'd4}, {3'd7, 3'd4, 3'd2});
    #2;
    checkOutput("trig_commit_en", 32'(bus.commit_en), 32'b001);
    checkOutput("trig_cnt_ret",   32'(cnt_retired),   32'd5);
    @(posedge clk); #3;
    checkOutput("flush_pulse",    32'(bus.flush),        32'd1);
    checkOutput("flush_restore",  32'(bus.restore_rat),  32'd1);
    checkOutput("flush_freeze",   32'(bus.freeze_front), 32'd1);
    checkOutput("flush_excep_Rw", 32'(excep_Rw),         32'd4);
    checkOutput("flush_cnt_exc",  32'(cnt_excep),        32'd1);
    checkOutput("flush_commit",   32'(bus.commit_en),    32'd0);
    @(posedge clk); #3;
    checkOutput("rec1_flush",     32'(bus.flush),        32'd0);
    checkOutput("rec1_freeze",    32'(bus.freeze_front), 32'd1);
    checkOutput("rec1_commit",    32'(bus.commit_en),    32'd0);
    @(posedge clk); #3;
    checkOutput("rec2_freeze",    32'(bus.freeze_front), 32'd1);
    checkOutput("rec2_cnt_exc",   32'(cnt_excep),        32'd1);
    applyStimulus(3'b111, 3'b000, 6'd0, 15'd0, 15'd0, 9'd0);
    #2;
    checkOutput("run_freeze",     32'(bus.freeze_front), 32'd0);
    checkOutput("run_commit_en",  32'(bus.commit_en),    32'b111);
    checkOutput("run_cnt_ret",    32'(cnt_retired),      32'd6);

    // Excepting slot2 behind a non-ready slot1 is not a trigger.
    applyStimulus(3'b001, 3'b100, 6'd0, 15'd0, 15'd0, {3'd5, 3'd0, 3'd0});
    #2;
    checkOutput("behind_commit_en", 32'(bus.commit_en), 32'b001);
    applyStimulus(3'b111, 3'b000, 6'd0, 15'd0, 15'd0, 9'd0);
    #2;
    checkOutput("behind_freeze",  32'(bus.freeze_front), 32'd0);
    checkOutput("behind_cnt_exc", 32'(cnt_excep),        32'd1);
    checkOutput("behind_cnt_ret", 32'(cnt_retired),      32'd10);
    applyStimulus(3'b111, 3'b000, 6'd0, 15'd0, 15'd0, 9'd0);
    idleCycle();
    #2;
    checkOutput("sat_cnt_ret",    32'(cnt_retired),      32'd15);

    // Exception at slot0, then reset asserted during recovery.
    applyStimulus(3'b001, 3'b001, 6'd0, 15'd0, 15'd0, {3'd0, 3'd0, 3'd6});
    #2;
    checkOutput("slot0_commit_en", 32'(bus.commit_en), 32'd0);
    @(posedge clk); #3;
    checkOutput("slot0_excep_Rw", 32'(excep_Rw),  32'd6);
    checkOutput("slot0_cnt_exc",  32'(cnt_excep), 32'd2);
    applyStimulus(3'b111, 3'b000, 6'd0, 15'd0, 15'd0, 9'd0);
    #1;
    checkOutput("pre_rst_freeze", 32'(bus.freeze_front), 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("arst_freeze",    32'(bus.freeze_front), 32'd0);
    checkOutput("arst_commit_en", 32'(bus.commit_en),    32'd0);
    checkOutput("arst_cnt_ret",   32'(cnt_retired),      32'd0);
    checkOutput("arst_cnt_exc",   32'(cnt_excep),        32'd0);
    checkOutput("arst_excep_Rw",  32'(excep_Rw),         32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    #2;
    checkOutput("post_rst_commit", 32'(bus.commit_en), 32'b111);
    idleCycle();
    #2;
    checkOutput("post_rst_cnt_ret", 32'(cnt_retired), 32'd3);

    // Sixteen exceptions rotating over slots; cnt_excep saturates at 15.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'b111, 3'(1 << (i % 3)), 6'd0, 15'd0, 15'd0,
                    {3'(i + 2), 3'(i + 1), 3'(i)});
      idleCycle();
      idleCycle();
      idleCycle();
    end
    idleCycle();
    #2;
    checkOutput("sat_cnt_exc",    32'(cnt_excep),   32'd15);
    checkOutput("last_excep_Rw",  32'(excep_Rw),    32'd7);
    checkOutput("loop_cnt_ret",   32'(cnt_retired), 32'd15);

    @(posedge clk); @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
